mult8_acc_stage: RTL and testbench



---
 rtl/mult8_acc_pkg.sv | 13 +
 rtl/mult8_acc_stage_acc_sat_add.sv | 20 ++
 rtl/mult8_acc_stage.sv | 115 +++++++++++
 tb/tb_mult8_acc_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult8_acc_pkg.sv
// Shared types and constants for the product-stream frame accumulator.
package mult8_acc_pkg;

  // Width of the unsigned product delivered by the 8x8 multipliers.
  localparam int PROD_W = 16;

  // ACCUM: summing beats of the current frame. HOLD: presenting a frame result.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/mult8_acc_stage_acc_sat_add.sv
// Combinational W-bit unsigned adder that clamps to all ones on carry-out.
module acc_sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] full;

  // Add with one extra bit; a carry means the true sum reached 2^W.
  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    ovf  = full[W];
    sum  = full[W] ? {W{1'b1}} : full[W-1:0];
  end

endmodule

// File: rtl/mult8_acc_stage.sv
// Frame accumulator: sums a frame of 16-bit products with saturation and
// presents total, beat count and sticky saturation flag on a held output.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is a pure decode of the state register (never of in_valid);
// out_valid is high for the whole HOLD state and its data stays stable
// until out_ready is seen.
module mult8_acc_stage
  import mult8_acc_pkg::*;
#(
  parameter  int ACC_W   = 24,
  parameter  int MAX_LEN = 256,
  localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat,
  output state_e            dbg_state
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_sat_q, out_sat_d;

  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;

  acc_sat_add #(.W(ACC_W)) u_add (
    .a   (acc_q),
    .b   ({{(ACC_W - PROD_W){1'b0}}, in_prod}),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;
  assign dbg_state = state_q;
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // Next-state: accumulate accepted beats, close frames, release on result handshake.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          sat_d = sat_q | add_ovf;
          // Close on an explicit last beat or when the frame reaches its maximum length.
          if (in_last || (cnt_inc == CNT_W'(MAX_LEN))) begin
            state_d     = HOLD;
            out_sum_d   = add_sum;
            out_count_d = cnt_inc;
            out_sat_d   = sat_q | add_ovf;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State, accumulator and output registers; async reset discards everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_mult8_acc_stage.sv
// Bench for mult8_acc_stage: instance A (ACC_W=24, MAX_LEN=4) and
// instance B (ACC_W=17, MAX_LEN=256), table-driven frames plus timing sequences.
module tb_mult8_acc_stage;
  import mult8_acc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_sat;
  logic [15:0] a_in_prod;
  logic [23:0] a_out_sum;
  logic [2:0]  a_out_count;
  state_e      a_state;
  // Instance B signals
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_sat;
  logic [15:0] b_in_prod;
  logic [16:0] b_out_sum;
  logic [8:0]  b_out_count;
  state_e      b_state;

  mult8_acc_stage #(.ACC_W(24), .MAX_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_prod(a_in_prod), .in_last(a_in_last), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_sum(a_out_sum), .out_count(a_out_count),
    .out_sat(a_out_sat), .dbg_state(a_state)
  );

  mult8_acc_stage #(.ACC_W(17), .MAX_LEN(256)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_prod(b_in_prod), .in_last(b_in_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_sum(b_out_sum), .out_count(b_out_count),
    .out_sat(b_out_sat), .dbg_state(b_state)
  );

  int total = 0;
  int bad   = 0;
  int pushed = 0;
  int seen   = 0;

  typedef struct packed {
    logic [31:0] sum;
    logic [15:0] cnt;
    logic        sat;
  } res_t;

  logic [48:0] exp_a[$];
  logic [48:0] exp_b[$];

  typedef struct packed {
    logic        sel;
    logic [3:0]  n;
    logic        close_last;
    logic [5:0][15:0] prod;
    logic [31:0] sum;
    logic [15:0] cnt;
    logic        sat;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic sel, input int n, input logic cl,
                              input int p0, input int p1, input int p2, input int p3,
                              input int p4, input int p5, input int s, input int c,
                              input logic sat);
    vec_t v;
    v.sel = sel; v.n = 4'(n); v.close_last = cl;
    v.prod[0] = 16'(p0); v.prod[1] = 16'(p1); v.prod[2] = 16'(p2);
    v.prod[3] = 16'(p3); v.prod[4] = 16'(p4); v.prod[5] = 16'(p5);
    v.sum = 32'(s); v.cnt = 16'(c); v.sat = sat;
    return v;
  endfunction

  task automatic push_exp(input logic sel, input int s, input int c, input logic sat);
    res_t r;
    r.sum = 32'(s); r.cnt = 16'(c); r.sat = sat;
    if (sel == 1'b0) exp_a.push_back(r);
    else exp_b.push_back(r);
    pushed++;
  endtask

  task automatic drive(input logic sel, input logic v, input logic [15:0] p, input logic l);
    if (sel == 1'b0) begin
      a_in_valid = v; a_in_prod = p; a_in_last = l;
    end else begin
      b_in_valid = v; b_in_prod = p; b_in_last = l;
    end
  endtask

  function automatic logic rdy(input logic sel);
    return (sel == 1'b0) ? a_in_ready : b_in_ready;
  endfunction

  // Called at a falling edge; returns at the falling edge after the beat is taken.
  task automatic send_beat(input logic sel, input logic [15:0] p, input logic l);
    int guard = 0;
    drive(sel, 1'b1, p, l);
    while (!rdy(sel) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("beat_accept_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic wait_drain(input logic sel);
    int guard = 0;
    while (((sel == 1'b0) ? exp_a.size() : exp_b.size()) != 0 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 30) chk("result_timeout", 32'(guard), 32'd0);
  endtask

  // Scoreboard for A: compare on each result handshake.
  always @(negedge clk) begin
    res_t e;
    #1;
    if (rst_n && a_out_valid && a_out_ready) begin
      seen++;
      if (exp_a.size() == 0) chk("a_unexpected_result", 32'd1, 32'd0);
      else begin
        e = exp_a.pop_front();
        chk("a_sum", 32'(a_out_sum), e.sum);
        chk("a_count", 32'(a_out_count), 32'(e.cnt));
        chk("a_sat", 32'(a_out_sat), 32'(e.sat));
      end
    end
  end

  // Scoreboard for B.
  always @(negedge clk) begin
    res_t e;
    #1;
    if (rst_n && b_out_valid && b_out_ready) begin
      seen++;
      if (exp_b.size() == 0) chk("b_unexpected_result", 32'd1, 32'd0);
      else begin
        e = exp_b.pop_front();
        chk("b_sum", 32'(b_out_sum), e.sum);
        chk("b_count", 32'(b_out_count), 32'(e.cnt));
        chk("b_sat", 32'(b_out_sat), 32'(e.sat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Frame table: A has MAX_LEN=4/ACC_W=24, B has ACC_W=17.
    tbl[0]  = mk(0, 3, 1, 100, 200, 300, 0, 0, 0, 600, 3, 0);
    tbl[1]  = mk(0, 1, 1, 7, 0, 0, 0, 0, 0, 7, 1, 0);
    tbl[2]  = mk(0, 4, 0, 1, 2, 3, 4, 0, 0, 10, 4, 0);
    tbl[3]  = mk(0, 4, 1, 65535, 65535, 65535, 65535, 0, 0, 262140, 4, 0);
    tbl[4]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[5]  = mk(1, 3, 1, 65535, 65535, 10, 0, 0, 0, 131071, 3, 1);
    tbl[6]  = mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 5, 1, 0);
    tbl[7]  = mk(1, 3, 1, 65535, 65535, 1, 0, 0, 0, 131071, 3, 0);
    tbl[8]  = mk(1, 3, 1, 65535, 65535, 2, 0, 0, 0, 131071, 3, 1);
    tbl[9]  = mk(1, 2, 1, 65535, 1, 0, 0, 0, 0, 65536, 2, 0);
    tbl[10] = mk(1, 6, 1, 65535, 65535, 65535, 0, 9, 4, 131071, 6, 1);

    drive(0, 1'b0, 16'd0, 1'b0);
    drive(1, 1'b0, 16'd0, 1'b0);
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;

    // Reset values while held and after release
    repeat (3) @(negedge clk);
    chk("rst_a_out_valid", 32'(a_out_valid), 0);
    chk("rst_a_in_ready", 32'(a_in_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_a_sum", 32'(a_out_sum), 0);
    chk("rst_a_count", 32'(a_out_count), 0);
    chk("rst_a_sat", 32'(a_out_sat), 0);
    chk("rst_b_in_ready", 32'(b_in_ready), 1);
    chk("rst_b_out_valid", 32'(b_out_valid), 0);

    // Table-driven frames
    for (int i = 0; i < 11; i++) begin
      push_exp(tbl[i].sel, int'(tbl[i].sum), int'(tbl[i].cnt), tbl[i].sat);
      for (int j = 0; j < int'(tbl[i].n); j++)
        send_beat(tbl[i].sel, tbl[i].prod[j], tbl[i].close_last && (j == int'(tbl[i].n) - 1));
      wait_drain(tbl[i].sel);
    end

    // Basic frame timing: one-cycle out_valid, one-cycle in_ready bubble
    push_exp(0, 600, 3, 0);
    send_beat(0, 16'd100, 1'b0);
    send_beat(0, 16'd200, 1'b0);
    send_beat(0, 16'd300, 1'b1);
    chk("basic_out_valid_hi", 32'(a_out_valid), 1);
    chk("basic_in_ready_lo", 32'(a_in_ready), 0);
    chk("basic_sum", 32'(a_out_sum), 600);
    @(negedge clk);
    chk("basic_out_valid_lo", 32'(a_out_valid), 0);
    chk("basic_in_ready_hi", 32'(a_in_ready), 1);
    wait_drain(0);

    // Back-pressure: result held for 5 cycles with in_valid asserted
    a_out_ready = 1'b0;
    push_exp(0, 130050, 2, 0);
    send_beat(0, 16'd65025, 1'b0);
    send_beat(0, 16'd65025, 1'b1);
    drive(0, 1'b1, 16'd7, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", 32'(a_out_valid), 1);
      chk("bp_sum_stable", 32'(a_out_sum), 130050);
      chk("bp_in_ready_lo", 32'(a_in_ready), 0);
      @(negedge clk);
    end
    push_exp(0, 7, 1, 0);
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(a_in_ready), 1);
    chk("bp_release_out_valid", 32'(a_out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 16'd0, 1'b0);
    chk("bp_next_sum", 32'(a_out_sum), 7);
    wait_drain(0);

    // Auto-close at MAX_LEN=4; fifth beat waits for the result handshake
    push_exp(0, 260100, 4, 0);
    for (int k = 0; k < 4; k++) send_beat(0, 16'd65025, 1'b0);
    chk("auto_out_valid", 32'(a_out_valid), 1);
    chk("auto_fifth_blocked", 32'(a_in_ready), 0);
    push_exp(0, 65025, 2, 0);
    send_beat(0, 16'd65025, 1'b0);
    chk("auto_after_fifth_valid", 32'(a_out_valid), 0);
    send_beat(0, 16'd0, 1'b1);
    wait_drain(0);

    // Reset mid-frame discards the partial frame
    send_beat(0, 16'd50, 1'b0);
    send_beat(0, 16'd60, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_sum", 32'(a_out_sum), 0);
    chk("midrst_count", 32'(a_out_count), 0);
    chk("midrst_in_ready", 32'(a_in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_exp(0, 3, 2, 0);
    send_beat(0, 16'd1, 1'b0);
    send_beat(0, 16'd2, 1'b1);
    wait_drain(0);

    repeat (3) @(negedge clk);
    chk("queue_a_empty", 32'(exp_a.size()), 0);
    chk("queue_b_empty", 32'(exp_b.size()), 0);
    chk("results_seen", 32'(seen), 32'(pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
